intr_ctrl: RTL and testbench

Programmable interrupt controller that merges up to 32 external interrupt lines into the single level interrupt request consumed by the coprocessor 0 exception unit. It synchronizes and edge/level-qualifies each source, holds per-source pending, mask and in-service state, and applies fixed priority (index 0 highest). Software claims the highest-priority source through a small register port on the CPU's uncached I/O space and signals completion with an end-of-interrupt (EOI) write. Nesting is allowed only for strictly higher-priority sources.

---
 rtl/intr_ctrl_pkg.sv | 37 +++
 rtl/intr_ctrl_if.sv | 30 +++
 rtl/intr_prio_enc.sv | 29 ++
 rtl/intr_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl_pkg
// Description : Shared constants, register map and claim-word helper for the
//               programmable interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_ctrl_pkg;

    // Largest source count the 5-bit id fields can address
    localparam int c_maxsrc      = 32;
    // Position of the valid flag in the CLAIM read word
    localparam int c_claim_valid = 31;

    // Register word indices on the CPU I/O port
    typedef enum logic [2:0] {
        c_reg_status = 3'd0,
        c_reg_pend   = 3'd1,
        c_reg_mask   = 3'd2,
        c_reg_mode   = 3'd3,
        c_reg_claim  = 3'd4,
        c_reg_eoi    = 3'd5,
        c_reg_insrv  = 3'd6,
        c_reg_rsvd   = 3'd7
    } pic_reg_e;

    // Builds {valid, 26'b0, id}; an invalid claim reads as all zeros
    function automatic logic [31:0] claim_word(input logic found, input logic [4:0] id);
        logic [31:0] w_word;
        w_word                = '0;
        w_word[c_claim_valid] = found;
        w_word[4:0]           = found ? id : 5'd0;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl_if
// Description : CPU register port of the interrupt controller (word index,
//               read/write strobes, write data, registered read data/valid).
// Revision    : 1.0 - initial release
// ============================================================================
interface intr_ctrl_if;

    logic [2:0]  i_addr;
    logic        i_rd;
    logic        i_wr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_rdy;

    // CPU side drives strobes and address, consumes read data
    modport master (
        output i_addr, i_rd, i_wr, i_wdata,
        input  o_rdata, o_rdy
    );

    // Controller side
    modport slave (
        input  i_addr, i_rd, i_wr, i_wdata,
        output o_rdata, o_rdy
    );

endinterface
`default_nettype wire

// File: rtl/intr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : intr_prio_enc
// Description : Find-first-set: reports whether any bit is set and the index
//               of the lowest set bit (index 0 has highest priority).
// Revision    : 1.0 - initial release
// ============================================================================
module intr_prio_enc #(
    parameter int W = 32
) (
    input  wire logic [W-1:0] i_vec,
    output logic              o_found,
    output logic [4:0]        o_idx
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        o_found = 1'b0;
        o_idx   = 5'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = 5'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl
// Description : Programmable interrupt controller. Synchronizes up to 32
//               sources, qualifies them as edge or level, tracks pending,
//               mask and in-service state, and raises a single registered
//               request for the highest-priority eligible source. Nesting is
//               limited to sources strictly above the highest one in service.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [NSRC-1:0] i_src,
    intr_ctrl_if.slave           bus,
    output logic                 o_intr
);

    // Architectural state
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_mode;
    logic [NSRC-1:0] r_insrv;
    logic            r_intr;
    logic [31:0]     r_rdata;
    logic            r_rdy;

    // Per-source combinational terms
    logic [NSRC-1:0] w_sync;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_insrv_nxt;
    logic [NSRC-1:0] w_claim_hit;
    logic [NSRC-1:0] w_eoi_hit;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_mode_sw;

    // Priority terms
    logic [NSRC-1:0] w_window;
    logic [NSRC-1:0] w_elig;
    logic            w_elig_found;
    logic [4:0]      w_best_idx;
    logic            w_ins_found;
    logic [4:0]      w_ins_idx;

    // Port decode
    pic_reg_e        w_addr;
    logic            w_rd_only;
    logic            w_wr_pend;
    logic            w_wr_mask;
    logic            w_wr_mode;
    logic            w_wr_eoi;
    logic            w_claim_go;
    logic [31:0]     w_rd_word;
    logic            w_unused_wdata;

    assign w_addr     = pic_reg_e'(bus.i_addr);
    // A simultaneous read and write performs only the write
    assign w_rd_only  = bus.i_rd && !bus.i_wr;
    assign w_wr_pend  = bus.i_wr && (w_addr == c_reg_pend);
    assign w_wr_mask  = bus.i_wr && (w_addr == c_reg_mask);
    assign w_wr_mode  = bus.i_wr && (w_addr == c_reg_mode);
    assign w_wr_eoi   = bus.i_wr && (w_addr == c_reg_eoi);
    assign w_claim_go = w_rd_only && (w_addr == c_reg_claim) && w_elig_found;

    // Upper write-data bits beyond NSRC have no destination
    assign w_unused_wdata = ^bus.i_wdata;

    // Lowest in-service index bounds which sources may nest
    intr_prio_enc #(.W(NSRC)) u_insrv_enc (
        .i_vec   (r_insrv),
        .o_found (w_ins_found),
        .o_idx   (w_ins_idx)
    );

    // Open window when idle, else only strictly higher-priority (lower) indices
    always_comb begin
        w_window = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_window[i] = !w_ins_found || (5'(i) < w_ins_idx);
        end
    end

    assign w_elig = r_pend & r_mask & w_window;

    intr_prio_enc #(.W(NSRC)) u_elig_enc (
        .i_vec   (w_elig),
        .o_found (w_elig_found),
        .o_idx   (w_best_idx)
    );

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        logic r_sync1;
        logic r_sync2;
        logic r_prev;

        // Two-flop synchronizer plus the delayed copy used for rising-edge detect
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_prev  <= 1'b0;
            end else begin
                r_sync1 <= i_src[g];
                r_sync2 <= r_sync1;
                r_prev  <= r_sync2;
            end
        end

        assign w_sync[g]      = r_sync2;
        assign w_rise[g]      = r_sync2 & ~r_prev;
        assign w_claim_hit[g] = w_claim_go && (w_best_idx == 5'(g));
        assign w_eoi_hit[g]   = w_wr_eoi && (bus.i_wdata[4:0] == 5'(g));
        assign w_w1c[g]       = w_wr_pend && bus.i_wdata[g];
        assign w_mode_sw[g]   = w_wr_mode && bus.i_wdata[g] && !r_mode[g];

        // Level mode tracks the line; edge mode: a new edge beats W1C or claim clears
        assign w_pend_nxt[g]  = w_mode_sw[g]                  ? 1'b0       :
                                !r_mode[g]                    ? w_sync[g]  :
                                w_rise[g]                     ? 1'b1       :
                                (w_w1c[g] | w_claim_hit[g])   ? 1'b0       :
                                                                r_pend[g];

        // Claim and EOI never share a cycle, so their order here is immaterial
        assign w_insrv_nxt[g] = w_claim_hit[g] ? 1'b1 :
                                w_eoi_hit[g]   ? 1'b0 :
                                                 r_insrv[g];
    end

    // Read-data mux; bits at or above NSRC stay zero
    always_comb begin
        w_rd_word = '0;
        case (w_addr)
            c_reg_status: begin
                w_rd_word[31]  = r_intr;
                w_rd_word[4:0] = w_elig_found ? w_best_idx : 5'd0;
            end
            c_reg_pend:   w_rd_word[NSRC-1:0] = r_pend;
            c_reg_mask:   w_rd_word[NSRC-1:0] = r_mask;
            c_reg_mode:   w_rd_word[NSRC-1:0] = r_mode;
            c_reg_claim:  w_rd_word = claim_word(w_elig_found, w_best_idx);
            c_reg_insrv:  w_rd_word[NSRC-1:0] = r_insrv;
            default:      w_rd_word = '0;
        endcase
    end

    // Controller state, request output and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_mode  <= '0;
            r_insrv <= '0;
            r_intr  <= 1'b0;
            r_rdata <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_insrv <= w_insrv_nxt;
            if (w_wr_mask) begin
                r_mask <= bus.i_wdata[NSRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= bus.i_wdata[NSRC-1:0];
            end
            r_intr <= w_elig_found;
            r_rdy  <= bus.i_rd;
            if (bus.i_rd) begin
                r_rdata <= w_rd_only ? w_rd_word : 32'd0;
            end
        end
    end

    assign o_intr      = r_intr;
    assign bus.o_rdata = r_rdata;
    assign bus.o_rdy   = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_ctrl
// Description : Directed self-checking bench for intr_ctrl (NSRC = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic       intr;
    logic [31:0] rdv;
    int         n_chk;
    int         n_fail;

    intr_ctrl_if bus ();

    intr_ctrl #(.NSRC(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_src  (src),
        .bus    (bus.slave),
        .o_intr (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.i_addr  = a;
        bus.i_wdata = d;
        bus.i_wr    = 1'b1;
        tick();
        bus.i_wr    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.i_addr = a;
        bus.i_rd   = 1'b1;
        tick();
        bus.i_rd   = 1'b0;
        check("rdy", {31'b0, bus.o_rdy}, 32'd1);
        d = bus.o_rdata;
    endtask

    task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic pulse(input int idx);
        src[idx] = 1'b1;
        tick();
        src[idx] = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        src         = '0;
        bus.i_addr  = '0;
        bus.i_rd    = 1'b0;
        bus.i_wr    = 1'b0;
        bus.i_wdata = '0;
        ticks(3);
        rst = 1'b0;

        // Reset state
        check("rst_intr",  {31'b0, intr}, 32'd0);
        check("rst_rdata", bus.o_rdata, 32'd0);
        check("rst_rdy",   {31'b0, bus.o_rdy}, 32'd0);

        // Edge source 0: three-cycle latency, claim, then request drops
        wr(3'd2, 32'h01);
        wr(3'd3, 32'h01);
        pulse(0);
        tick();
        check("t1_intr_k1", {31'b0, intr}, 32'd0);
        tick();
        check("t1_intr_k2", {31'b0, intr}, 32'd0);
        tick();
        check("t1_intr_k3", {31'b0, intr}, 32'd1);
        rchk("t1_claim", 3'd4, 32'h8000_0000);
        check("t1_intr_at_claim", {31'b0, intr}, 32'd1);
        tick();
        check("t1_rdy_pulse", {31'b0, bus.o_rdy}, 32'd0);
        check("t1_rdata_hold", bus.o_rdata, 32'h8000_0000);
        check("t1_intr_drop", {31'b0, intr}, 32'd0);
        rchk("t1_pend", 3'd1, 32'h0);
        wr(3'd5, 32'd0);
        rchk("t1_insrv", 3'd6, 32'h0);

        // Level sources 3 and 5: window blocks 5 while 3 is in service
        wr(3'd2, 32'hFF);
        wr(3'd3, 32'h00);
        src[3] = 1'b1;
        src[5] = 1'b1;
        ticks(4);
        check("t2_intr", {31'b0, intr}, 32'd1);
        rchk("t2_claim3", 3'd4, 32'h8000_0003);
        src[3] = 1'b0;
        tick();
        check("t2_intr_blocked", {31'b0, intr}, 32'd0);
        ticks(4);
        rchk("t2_pend", 3'd1, 32'h20);
        wr(3'd5, 32'd3);
        tick();
        check("t2_intr_after_eoi", {31'b0, intr}, 32'd1);
        rchk("t2_status", 3'd0, 32'h8000_0005);
        rchk("t2_claim5", 3'd4, 32'h8000_0005);
        src[5] = 1'b0;
        wr(3'd5, 32'd5);
        ticks(4);
        rchk("t2_pend_clr", 3'd1, 32'h0);
        rchk("t2_insrv_clr", 3'd6, 32'h0);

        // Nesting: 4 in service, 1 nests, 6 waits for both EOIs
        wr(3'd3, 32'hFF);
        pulse(4);
        ticks(3);
        check("t3_intr4", {31'b0, intr}, 32'd1);
        rchk("t3_claim4", 3'd4, 32'h8000_0004);
        pulse(1);
        ticks(3);
        check("t3_intr1", {31'b0, intr}, 32'd1);
        rchk("t3_claim1", 3'd4, 32'h8000_0001);
        rchk("t3_insrv", 3'd6, 32'h12);
        pulse(6);
        ticks(3);
        check("t3_intr6_blocked", {31'b0, intr}, 32'd0);
        rchk("t3_pend6", 3'd1, 32'h40);
        wr(3'd5, 32'd1);
        tick();
        check("t3_intr_after_eoi1", {31'b0, intr}, 32'd0);
        wr(3'd5, 32'd4);
        tick();
        check("t3_intr_after_eoi4", {31'b0, intr}, 32'd1);
        rchk("t3_claim6", 3'd4, 32'h8000_0006);
        wr(3'd5, 32'd6);
        rchk("t3_insrv_clr", 3'd6, 32'h0);

        // Edge on source 2 against W1C
        pulse(2);
        ticks(3);
        rchk("t4_pend_set", 3'd1, 32'h04);
        wr(3'd1, 32'h04);
        rchk("t4_w1c", 3'd1, 32'h00);
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        tick();
        wr(3'd1, 32'h04);
        rchk("t4_edge_wins", 3'd1, 32'h04);
        wr(3'd1, 32'h04);
        rchk("t4_clr_again", 3'd1, 32'h00);

        // Idle claim, stray EOI, reserved index, width clipping, rd+wr collision
        rchk("t5_claim_none", 3'd4, 32'h0);
        rchk("t5_insrv", 3'd6, 32'h0);
        wr(3'd5, 32'd7);
        rchk("t5_insrv_eoi7", 3'd6, 32'h0);
        wr(3'd7, 32'hFFFF_FFFF);
        rchk("t5_rsvd", 3'd7, 32'h0);
        wr(3'd2, 32'hFFFF_FFFF);
        rchk("t5_mask_clip", 3'd2, 32'hFF);
        bus.i_addr  = 3'd2;
        bus.i_wdata = 32'h0F;
        bus.i_rd    = 1'b1;
        bus.i_wr    = 1'b1;
        tick();
        bus.i_rd    = 1'b0;
        bus.i_wr    = 1'b0;
        check("t5_rdwr_data", bus.o_rdata, 32'h0);
        rchk("t5_rdwr_mask", 3'd2, 32'h0F);

        // Reset aborts a claim in flight
        wr(3'd3, 32'h01);
        wr(3'd2, 32'h01);
        pulse(0);
        ticks(3);
        check("t6_intr_pre", {31'b0, intr}, 32'd1);
        bus.i_addr = 3'd4;
        bus.i_rd   = 1'b1;
        rst        = 1'b1;
        tick();
        bus.i_rd   = 1'b0;
        rst        = 1'b0;
        check("t6_rdy", {31'b0, bus.o_rdy}, 32'd0);
        check("t6_rdata", bus.o_rdata, 32'h0);
        check("t6_intr", {31'b0, intr}, 32'd0);
        for (int a = 0; a < 7; a++) begin
            rchk("t6_reg", 3'(a), 32'h0);
        end
        check("t6_intr_end", {31'b0, intr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
